lbp_param: RTL and testbench

LBP_PARAM -- requirements
Module: lbp_param

---
 rtl/lbp_param.sv | 219 +++++++++++++++++++++
 tb/tb_lbp_param.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_param.sv
// Local binary pattern engine: fetches a 3x3 window over a serial sliced address bus
// and writes one 8-bit LBP code per interior pixel over a sliced result bus.
module lbp_param #(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int ASLICE = 4,
   parameter int DSLICE = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gray_ready,
   output logic              gray_req,
   output logic [ASLICE-1:0] gray_addr_s,
   input  logic [7:0]        gray_data,
   input  logic              mode,
   input  logic [7:0]        thr,
   output logic              lbp_valid,
   output logic [ASLICE-1:0] lbp_addr_s,
   output logic [DSLICE-1:0] lbp_data_s,
   output logic              finish
);

   localparam int ADDR_W = $clog2(IMG_W * IMG_H);
   localparam int NA     = (ADDR_W + ASLICE - 1) / ASLICE;
   localparam int ND     = 8 / DSLICE;
   localparam int NW     = (NA > ND) ? NA : ND;
   localparam int AP_W   = NA * ASLICE;
   localparam int KW     = $clog2(NW) + 1;
   localparam int RW     = $clog2(IMG_H);
   localparam int CW     = $clog2(IMG_W);

   localparam logic [RW-1:0]   ROW_FIRST = RW'(1);
   localparam logic [RW-1:0]   ROW_LAST  = RW'(IMG_H - 2);
   localparam logic [CW-1:0]   COL_FIRST = CW'(1);
   localparam logic [CW-1:0]   COL_LAST  = CW'(IMG_W - 2);
   localparam logic [KW-1:0]   K_NA_LAST = KW'(NA - 1);
   localparam logic [KW-1:0]   K_NW_LAST = KW'(NW - 1);
   localparam logic [KW-1:0]   K_ONE     = KW'(1);
   localparam logic [AP_W-1:0] W_A       = AP_W'(IMG_W);
   localparam logic [AP_W-1:0] A_ONE     = AP_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      COMPUTE,
      WRITE,
      DONE
   } state_t;

   state_t          state, state_nx;
   logic [RW-1:0]   row;
   logic [CW-1:0]   col;
   logic [1:0]      dr, dc;
   logic [KW-1:0]   k;
   logic            mode_r;
   logic [7:0]      thr_r;
   logic [7:0]      win [9];
   logic [7:0]      lbp_code;

   logic [AP_W-1:0] fetch_addr, out_addr;
   logic [3:0]      widx;
   logic            fetch_last, img_last, full_fetch;
   logic [7:0]      ref_v;
   logic [63:0]     nbr;
   logic [7:0]      lbp_next;

   function automatic logic [7:0] sat_ref(input logic [7:0] c, input logic [7:0] t);
      logic [8:0] s;
      s = {1'b0, c} + {1'b0, t};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   function automatic logic [ASLICE-1:0] addr_slice(input logic [AP_W-1:0] a,
                                                    input logic [KW-1:0]   idx);
      logic [AP_W-1:0] t;
      t = a >> (int'(idx) * ASLICE);
      return t[ASLICE-1:0];
   endfunction

   function automatic logic [DSLICE-1:0] data_slice(input logic [7:0]    d,
                                                    input logic [KW-1:0] idx);
      logic [7:0] t;
      t = d >> (int'(idx) * DSLICE);
      return t[DSLICE-1:0];
   endfunction

   // (dr, dc) walk the window: full 3x3 at a row start, right column only otherwise
   assign full_fetch = (col == COL_FIRST);
   assign fetch_last = (dr == 2'd2) && (dc == 2'd2);
   assign img_last   = (row == ROW_LAST) && (col == COL_LAST);
   assign widx       = {dr, 2'b00} - {2'b00, dr} + {2'b00, dc};
   assign fetch_addr = (AP_W'(row) + AP_W'(dr) - A_ONE) * W_A + AP_W'(col) + AP_W'(dc) - A_ONE;
   assign out_addr   = AP_W'(row) * W_A + AP_W'(col);

   always_comb begin
      ref_v    = mode_r ? sat_ref(win[4], thr_r) : win[4];
      nbr      = {win[8], win[7], win[6], win[5], win[3], win[2], win[1], win[0]};
      lbp_next = '0;
      for (int i = 0; i < 8; i++) begin
         lbp_next[i] = (nbr[i*8 +: 8] >= ref_v);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      gray_req    = 1'b0;
      gray_addr_s = '0;
      lbp_valid   = 1'b0;
      lbp_addr_s  = '0;
      lbp_data_s  = '0;
      finish      = 1'b0;
      case (state)
         IDLE: begin
            if (gray_ready) state_nx = FETCH;
         end
         FETCH: begin
            gray_req    = 1'b1;
            gray_addr_s = addr_slice(fetch_addr, k);
            if (k == K_NA_LAST) state_nx = CAPTURE;
         end
         CAPTURE: begin
            state_nx = fetch_last ? COMPUTE : FETCH;
         end
         COMPUTE: begin
            state_nx = WRITE;
         end
         WRITE: begin
            lbp_valid  = 1'b1;
            lbp_addr_s = addr_slice(out_addr, k);
            lbp_data_s = data_slice(lbp_code, k);
            if (k == K_NW_LAST) state_nx = img_last ? DONE : FETCH;
         end
         DONE: begin
            finish = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row      <= '0;
         col      <= '0;
         dr       <= '0;
         dc       <= '0;
         k        <= '0;
         mode_r   <= 1'b0;
         thr_r    <= '0;
         lbp_code <= '0;
         for (int i = 0; i < 9; i++) win[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gray_ready) begin
                  row    <= ROW_FIRST;
                  col    <= COL_FIRST;
                  dr     <= '0;
                  dc     <= '0;
                  k      <= '0;
                  mode_r <= mode;
                  thr_r  <= thr;
               end
            end
            FETCH: begin
               k <= (k == K_NA_LAST) ? '0 : k + K_ONE;
            end
            CAPTURE: begin
               win[widx] <= gray_data;
               if (!fetch_last) begin
                  if (full_fetch && dc != 2'd2) begin
                     dc <= dc + 2'd1;
                  end else begin
                     dc <= full_fetch ? 2'd0 : 2'd2;
                     dr <= dr + 2'd1;
                  end
               end
            end
            COMPUTE: begin
               lbp_code <= lbp_next;
               k        <= '0;
            end
            WRITE: begin
               if (k == K_NW_LAST) begin
                  k  <= '0;
                  dr <= '0;
                  if (col == COL_LAST) begin
                     col <= COL_FIRST;
                     row <= row + ROW_FIRST;
                     dc  <= 2'd0;
                  end else begin
                     // slide left; the right column is refilled by the next fetch
                     col    <= col + COL_FIRST;
                     dc     <= 2'd2;
                     win[0] <= win[1];
                     win[1] <= win[2];
                     win[3] <= win[4];
                     win[4] <= win[5];
                     win[6] <= win[7];
                     win[7] <= win[8];
                  end
               end else begin
                  k <= k + K_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lbp_param.sv
// Bench for lbp_param: a 4x4 instance driven with random and directed images,
// plus a wide instance whose first pixel sits at address 0x2A5B.
module tb_lbp_param;

   localparam int AW   = 4;
   localparam int AH   = 4;
   localparam int A_NA = 1;
   localparam int A_NW = 4;
   localparam int BW   = 10842;
   localparam int BH   = 3;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;

   logic       a_ready = 1'b0, a_mode = 1'b0;
   logic [7:0] a_thr = 8'd0;
   logic [7:0] a_gray_data = 8'd0;
   logic       a_gray_req, a_lbp_valid, a_finish;
   logic [3:0] a_gray_addr_s, a_lbp_addr_s;
   logic [1:0] a_lbp_data_s;

   logic       b_ready = 1'b0, b_mode = 1'b0;
   logic [7:0] b_thr = 8'd37;
   logic [7:0] b_gray_data = 8'd0;
   logic       b_gray_req, b_lbp_valid, b_finish;
   logic [3:0] b_gray_addr_s, b_lbp_addr_s;
   logic [1:0] b_lbp_data_s;

   lbp_param #(.IMG_W(AW), .IMG_H(AH), .ASLICE(4), .DSLICE(2)) u_a (
      .clk(clk), .reset(reset), .gray_ready(a_ready), .gray_req(a_gray_req),
      .gray_addr_s(a_gray_addr_s), .gray_data(a_gray_data), .mode(a_mode), .thr(a_thr),
      .lbp_valid(a_lbp_valid), .lbp_addr_s(a_lbp_addr_s), .lbp_data_s(a_lbp_data_s),
      .finish(a_finish)
   );

   lbp_param #(.IMG_W(BW), .IMG_H(BH)) u_b (
      .clk(clk), .reset(reset), .gray_ready(b_ready), .gray_req(b_gray_req),
      .gray_addr_s(b_gray_addr_s), .gray_data(b_gray_data), .mode(b_mode), .thr(b_thr),
      .lbp_valid(b_lbp_valid), .lbp_addr_s(b_lbp_addr_s), .lbp_data_s(b_lbp_data_s),
      .finish(b_finish)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   logic [7:0] img_a [AW*AH];

   // state owned by the monitor process only
   int cyc = 0, viol = 0, early_fin = 0, last_push_cyc = 0, fin_cyc = -1;
   int clr_seq = 0, clr_seen = 0;
   int a_gk = 0, a_gacc = 0, a_wk = 0, a_wacc = 0, a_dacc = 0;
   int b_gk = 0, b_gacc = 0;
   int fq_a[$], oa_q[$], od_q[$];
   int b_gsl[$], b_wa[$], b_wd[$];

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   function automatic logic [7:0] mem_b(input int a);
      if (a == 0 || a == BW || a == 2*BW + 1 || a == 2*BW + 2) return 8'd200;
      if (a == BW + 1) return 8'd100;
      return 8'd50;
   endfunction

   function automatic int model_lbp(input int r, input int c, input int m, input int t);
      int dy[8];
      int dx[8];
      int ctr, rf, res;
      dy  = '{-1, -1, -1, 0, 0, 1, 1, 1};
      dx  = '{-1, 0, 1, -1, 1, -1, 0, 1};
      ctr = int'(img_a[r*AW + c]);
      rf  = (m != 0) ? ((ctr + t > 255) ? 255 : ctr + t) : ctr;
      res = 0;
      for (int i = 0; i < 8; i++)
         if (int'(img_a[(r + dy[i])*AW + c + dx[i]]) >= rf) res += (1 << i);
      return res;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (clr_seen != clr_seq) begin
         clr_seen = clr_seq;
         fq_a.delete(); oa_q.delete(); od_q.delete();
         viol = 0; early_fin = 0; fin_cyc = -1;
      end
      if (!reset) begin
         a_gk = 0; a_gacc = 0; a_wk = 0; a_wacc = 0; a_dacc = 0; b_gk = 0; b_gacc = 0;
      end else begin
         if (a_gray_req && a_lbp_valid) viol++;
         if (b_gray_req && b_lbp_valid) viol++;
         if (a_gray_req) begin
            a_gacc = a_gacc | (int'(a_gray_addr_s) << (4*a_gk));
            a_gk++;
            if (a_gk == A_NA) begin
               fq_a.push_back(a_gacc);
               a_gray_data = img_a[a_gacc % (AW*AH)];
               a_gk = 0; a_gacc = 0;
            end
         end
         if (a_lbp_valid) begin
            a_wacc = a_wacc | (int'(a_lbp_addr_s) << (4*a_wk));
            a_dacc = a_dacc | (int'(a_lbp_data_s) << (2*a_wk));
            a_wk++;
            if (a_wk == A_NW) begin
               oa_q.push_back(a_wacc);
               od_q.push_back(a_dacc);
               last_push_cyc = cyc;
               if (a_finish) early_fin++;
               a_wk = 0; a_wacc = 0; a_dacc = 0;
            end
         end
         if (a_finish && fin_cyc < 0) fin_cyc = cyc;
         if (b_gray_req) begin
            if (b_gsl.size() < 40) b_gsl.push_back(int'(b_gray_addr_s));
            b_gacc = b_gacc | (int'(b_gray_addr_s) << (4*b_gk));
            b_gk++;
            if (b_gk == 4) begin
               b_gray_data = mem_b(b_gacc);
               b_gk = 0; b_gacc = 0;
            end
         end
         if (b_lbp_valid && b_wa.size() < 8) begin
            b_wa.push_back(int'(b_lbp_addr_s));
            b_wd.push_back(int'(b_lbp_data_s));
         end
      end
   end

   task automatic do_reset(input string tag);
      @(posedge clk); #1;
      reset = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
      #1;
      chk({tag, "_rst_a"}, int'({a_gray_req, a_gray_addr_s, a_lbp_valid, a_lbp_addr_s,
                                a_lbp_data_s, a_finish}), 0);
      chk({tag, "_rst_b"}, int'({b_gray_req, b_gray_addr_s, b_lbp_valid, b_lbp_addr_s,
                                b_lbp_data_s, b_finish}), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic start_a(input int m, input int t);
      clr_seq++;
      @(negedge clk);
      a_mode = m[0];
      a_thr  = t[7:0];
      @(posedge clk); #1 a_ready = 1'b1;
      @(posedge clk); #1 a_ready = 1'b0;
      // scrambled after sampling: the run must keep the captured values
      a_mode = ~a_mode;
      a_thr  = 8'($urandom);
   endtask

   task automatic check_run(input int m, input int t, input string tag);
      int ea[$], ed[$], ef[$];
      for (int r = 1; r <= AH - 2; r++)
         for (int c = 1; c <= AW - 2; c++) begin
            ea.push_back(r*AW + c);
            ed.push_back(model_lbp(r, c, m, t));
            if (c == 1) begin
               for (int y = 0; y < 3; y++)
                  for (int x = 0; x < 3; x++) ef.push_back((r - 1 + y)*AW + c - 1 + x);
            end else begin
               for (int y = 0; y < 3; y++) ef.push_back((r - 1 + y)*AW + c + 1);
            end
         end
      chk({tag, "_n_out"}, oa_q.size(), ea.size());
      for (int i = 0; i < ea.size(); i++)
         if (i < oa_q.size()) begin
            chk({tag, "_addr"}, oa_q[i], ea[i]);
            chk({tag, "_lbp"}, od_q[i], ed[i]);
         end
      chk({tag, "_n_fetch"}, fq_a.size(), ef.size());
      for (int i = 0; i < ef.size(); i++)
         if (i < fq_a.size()) chk({tag, "_fetch"}, fq_a[i], ef[i]);
   endtask

   task automatic finish_a(input int m, input int t, input bit toggle, input string tag);
      for (int n = 0; n < 3000 && !a_finish; n++) begin
         @(posedge clk); #1;
         if (toggle) a_ready = 1'($urandom_range(0, 1));
      end
      a_ready = 1'b0;
      if (!a_finish) chk({tag, "_timeout"}, 0, 1);
      @(negedge clk); #1;
      chk({tag, "_fin_lag"}, fin_cyc - last_push_cyc, 1);
      chk({tag, "_early_fin"}, early_fin, 0);
      chk({tag, "_mutex"}, viol, 0);
      chk({tag, "_done_outs"}, int'({a_gray_req, a_gray_addr_s, a_lbp_valid, a_lbp_addr_s,
                                    a_lbp_data_s, a_finish}), 1);
      check_run(m, t, tag);
      do_reset(tag);
   endtask

   task automatic run_a(input int m, input int t, input bit toggle, input string tag);
      start_a(m, t);
      finish_a(m, t, toggle, tag);
   endtask

   initial begin
      int exp_s[4];
      int exp_d[4];
      int m, t, quiet;
      #1;
      chk("rst_a_outs", int'({a_gray_req, a_gray_addr_s, a_lbp_valid, a_lbp_addr_s,
                              a_lbp_data_s, a_finish}), 0);
      chk("rst_b_outs", int'({b_gray_req, b_gray_addr_s, b_lbp_valid, b_lbp_addr_s,
                              b_lbp_data_s, b_finish}), 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // wide image: pixel (1,1) lives at 0x2A5B, its code is 0xC9
      @(posedge clk); #1 b_ready = 1'b1;
      @(posedge clk); #1 b_ready = 1'b0;
      for (int n = 0; n < 2000 && b_wa.size() < 4; n++) @(posedge clk);
      @(negedge clk); #1;
      exp_s = '{11, 5, 10, 2};
      exp_d = '{1, 2, 0, 3};
      if (b_wa.size() < 4 || b_gsl.size() < 20) begin
         chk("b_timeout", 0, 1);
      end else begin
         for (int i = 0; i < 4; i++) begin
            chk("b_lbp_addr_s", b_wa[i], exp_s[i]);
            chk("b_lbp_data_s", b_wd[i], exp_d[i]);
            chk("b_gray_addr_s", b_gsl[16 + i], exp_s[i]);
            chk("b_first_fetch", b_gsl[i], 0);
         end
      end
      do_reset("b");

      // ramp image with gray_ready toggling throughout
      for (int i = 0; i < AW*AH; i++) img_a[i] = 8'(i);
      run_a(0, 0, 1'b1, "ramp");

      for (int i = 0; i < AW*AH; i++) img_a[i] = 8'd50;
      start_a(0, 0);
      finish_a(0, 0, 1'b0, "uni_m0");
      for (int i = 0; i < od_q.size(); i++) chk("uni_m0_ff", od_q[i], 255);
      start_a(1, 1);
      finish_a(1, 1, 1'b1, "uni_m1");
      for (int i = 0; i < od_q.size(); i++) chk("uni_m1_00", od_q[i], 0);

      for (int i = 0; i < AW*AH; i++) img_a[i] = 8'd254;
      img_a[0] = 8'd255;
      img_a[5] = 8'd250;
      start_a(1, 10);
      finish_a(1, 10, 1'b0, "sat");
      chk("sat_px11", (od_q.size() > 0) ? od_q[0] : -1, 1);

      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < AW*AH; i++)
            img_a[i] = (it % 2 == 1) ? 8'(100 + $urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         m = int'($urandom_range(0, 1));
         t = (it % 4 == 3) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 3));
         run_a(m, t, 1'b1, "rand");
      end

      // reset in the 2nd write cycle of the first pixel
      for (int i = 0; i < AW*AH; i++) img_a[i] = 8'($urandom_range(0, 255));
      start_a(0, 0);
      for (int n = 0; n < 500 && !a_lbp_valid; n++) begin
         @(posedge clk); #1;
      end
      chk("rw_reach_write", int'(a_lbp_valid), 1);
      @(posedge clk); #1;
      chk("rw_2nd_cycle", int'(a_lbp_valid), 1);
      reset = 1'b0;
      #1;
      chk("rw_outs_zero", int'({a_gray_req, a_gray_addr_s, a_lbp_valid, a_lbp_addr_s,
                                a_lbp_data_s, a_finish}), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      quiet = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (a_gray_req || a_lbp_valid || a_finish) quiet++;
      end
      chk("rw_idle_quiet", quiet, 0);
      chk("rw_no_out", oa_q.size(), 0);
      start_a(0, 0);
      finish_a(0, 0, 1'b1, "rw");
      chk("rw_first_addr", (oa_q.size() > 0) ? oa_q[0] : -1, 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
